gpio_serial_loader: RTL



---
 rtl/gpio_cfg_pkg.sv | 32 +++
 rtl/gpio_serial_phase.sv | 39 +++
 rtl/gpio_serial_loader.sv | 128 ++++++++++++
 3 files changed

// File: rtl/gpio_cfg_pkg.sv
// GPIO pad configuration shared definitions: word size, field
// positions inside a pad word and the serial loader FSM states.
`ifndef MPRJ_IO_PADS
`define MPRJ_IO_PADS 38
`endif

package gpio_cfg_pkg;

  localparam int CFG_BITS = 13;

  localparam int MGMT_ENA_BIT    = 0;
  localparam int OEB_BIT         = 1;
  localparam int HLDH_BIT        = 2;
  localparam int INP_DIS_BIT     = 3;
  localparam int IB_MODE_SEL_BIT = 4;
  localparam int ANALOG_EN_BIT   = 5;
  localparam int ANALOG_SEL_BIT  = 6;
  localparam int ANALOG_POL_BIT  = 7;
  localparam int SLOW_SEL_BIT    = 8;
  localparam int VTRIP_SEL_BIT   = 9;
  localparam int DM_LSB          = 10;
  localparam int DM_MSB          = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LOAD,
    ST_DONE
  } state_e;

endpackage

// File: rtl/gpio_serial_phase.sv
// Phase timer: phase_end is high in the CLK_DIV-th cycle after restart.
// Ports: clk, rst (sync, active-high), restart in, phase_end out.
module gpio_serial_phase #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic phase_end
);

  localparam int PW = $clog2(CLK_DIV + 1);
  localparam logic [PW-1:0] DIV = PW'(CLK_DIV);
  localparam logic [PW-1:0] ONE = PW'(1);

  logic [PW-1:0] cnt_q, cnt_d;

  // restart is asserted on the edge that enters a new state, so the
  // first cycle of every state sees a freshly loaded count.
  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = DIV;
    end else if (cnt_q > ONE) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= DIV;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phase_end = (cnt_q == ONE);

endmodule

// File: rtl/gpio_serial_loader.sv
// Shifts every pad config word into the GPIO control-block chain, then
// strobes serial_load. Ports: wb_clk_i, wb_rst_i, start, cfg_data in;
// busy, done, serial_clock, serial_load, serial_data_out out.
module gpio_serial_loader #(
  parameter int IO_PADS  = `MPRJ_IO_PADS,
  parameter int CFG_BITS = gpio_cfg_pkg::CFG_BITS,
  parameter int CLK_DIV  = 4
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        start,
  input  logic [IO_PADS*CFG_BITS-1:0] cfg_data,
  output logic                        busy,
  output logic                        done,
  output logic                        serial_clock,
  output logic                        serial_load,
  output logic                        serial_data_out
);

  import gpio_cfg_pkg::*;

  localparam int N  = IO_PADS * CFG_BITS;
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam logic [BW-1:0] LAST = BW'(N - 1);
  localparam logic [BW-1:0] ONE  = BW'(1);

  state_e         state_q, state_d;
  logic [N-1:0]   snap_q, snap_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           sclk_q, sclk_d;
  logic           load_q, load_d;
  logic           sdo_q, sdo_d;
  logic           phase_end;
  logic           restart;

  gpio_serial_phase #(
    .CLK_DIV(CLK_DIV)
  ) u_phase (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .restart  (restart),
    .phase_end(phase_end)
  );

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    bit_d   = bit_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          snap_d  = cfg_data;
          bit_d   = LAST;
          state_d = ST_SHIFT_LO;
        end
      end
      ST_SHIFT_LO: begin
        if (phase_end) state_d = ST_SHIFT_HI;
      end
      ST_SHIFT_HI: begin
        if (phase_end) begin
          if (bit_q == '0) begin
            state_d = ST_LOAD;
          end else begin
            bit_d   = bit_q - ONE;
            state_d = ST_SHIFT_LO;
          end
        end
      end
      ST_LOAD: begin
        if (phase_end) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Every transition changes state, so a state change marks entry.
  assign restart = (state_d != state_q);

  // Outputs are decoded from the next state and registered so the
  // chain sees glitch-free clock, load and data lines.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    sclk_d = (state_d == ST_SHIFT_HI);
    load_d = (state_d == ST_LOAD);
    sdo_d  = 1'b0;
    if (state_d == ST_SHIFT_LO || state_d == ST_SHIFT_HI) begin
      sdo_d = snap_d[bit_d];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      snap_q  <= '0;
      bit_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      load_q  <= 1'b0;
      sdo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      load_q  <= load_d;
      sdo_q   <= sdo_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign serial_clock    = sclk_q;
  assign serial_load     = load_q;
  assign serial_data_out = sdo_q;

endmodule
